// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: run-control state encoding and default PC width.
package pc_sequencer_pkg;

  localparam int PC_W_DEFAULT = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_pc_next_calc.sv
// Combinational next-PC candidate: soft-reset restore, signed-direction branch, or sequential step.
module pc_next_calc
  import pc_sequencer_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic [PC_W-1:0] pc_i,
  input  logic            branch_i,
  input  logic [7:0]      boffset_i,
  input  logic            bsign_i,
  input  logic            soft_rst_i,
  input  logic [PC_W-1:0] base_i,
  output logic [PC_W-1:0] pc_next_o
);

  logic [PC_W-1:0] offset_ext;

  assign offset_ext = PC_W'(boffset_i);

  // Wrap-around modulo 2^PC_W falls out of the fixed result width.
  always_comb begin
    pc_next_o = pc_i + PC_W'(1);
    if (soft_rst_i) begin
      pc_next_o = base_i;
    end else if (branch_i) begin
      pc_next_o = bsign_i ? (pc_i - offset_ext) : (pc_i + offset_ext);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter and run-control sequencer (IDLE/RUN/HALTED) with START/DONE handshake.
// Optional retired-instruction counter enabled by defining SEQ_CYCLE_COUNT_EN.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int              PC_W          = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] START_DEFAULT = '0
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            START,
  input  logic [PC_W-1:0] START_ADDR,
  input  logic            STALL,
  input  logic            BRANCH,
  input  logic [7:0]      bOFFSET,
  input  logic            bSIGN,
  input  logic            SOFT_RST,
  input  logic            HALT_REQ,
  output logic [PC_W-1:0] PC,
  output logic            FETCH_EN,
  output logic            DONE,
  output logic [15:0]     CYCLE_CNT
);

  seq_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] base_q, base_d;
  logic [PC_W-1:0] pc_cand;
  logic            start_take;
  logic            retire;

  // START is honoured only outside RUN; a retire is any non-stalled RUN cycle.
  assign start_take = (state_q != RUN) && START;
  assign retire     = (state_q == RUN) && !STALL;

  pc_next_calc #(.PC_W(PC_W)) u_pc_next_calc (
    .pc_i       (pc_q),
    .branch_i   (BRANCH),
    .boffset_i  (bOFFSET),
    .bsign_i    (bSIGN),
    .soft_rst_i (SOFT_RST),
    .base_i     (base_q),
    .pc_next_o  (pc_cand)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      pc_q    <= START_DEFAULT;
      base_q  <= START_DEFAULT;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START) state_d = RUN;
      RUN:     if (!STALL && HALT_REQ) state_d = HALTED;
      HALTED:  if (START) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // A halt without soft reset freezes the PC on the halting instruction.
  always_comb begin
    pc_d   = pc_q;
    base_d = base_q;
    if (start_take) begin
      pc_d   = START_ADDR;
      base_d = START_ADDR;
    end else if (retire) begin
      if (!(HALT_REQ && !SOFT_RST)) pc_d = pc_cand;
    end
  end

  always_comb begin
    PC       = pc_q;
    FETCH_EN = (state_q == RUN);
    DONE     = (state_q == HALTED);
  end

`ifdef SEQ_CYCLE_COUNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q <= '0;
    end else if (start_take) begin
      cnt_q <= '0;
    end else if (retire && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign CYCLE_CNT = cnt_q;
`else
  assign CYCLE_CNT = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes reference-model expectations, a monitor pops and compares.
module tb_pc_sequencer;

  localparam int PC_W = 10;
  localparam int PC_MOD = 1 << PC_W;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            fe;
    logic            done;
    logic [15:0]     cnt;
  } exp_t;

  logic            CLK = 1'b0;
  logic            RESET_N;
  logic            START;
  logic [PC_W-1:0] START_ADDR;
  logic            STALL;
  logic            BRANCH;
  logic [7:0]      bOFFSET;
  logic            bSIGN;
  logic            SOFT_RST;
  logic            HALT_REQ;
  logic [PC_W-1:0] PC;
  logic            FETCH_EN;
  logic            DONE;
  logic [15:0]     CYCLE_CNT;

  int total = 0;
  int bad   = 0;

  exp_t exp_q[$];

  // Reference model: mode 0 = idle, 1 = running, 2 = halted.
  int m_mode, m_pc, m_base, m_cnt;

  pc_sequencer #(.PC_W(PC_W), .START_DEFAULT('0)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .START      (START),
    .START_ADDR (START_ADDR),
    .STALL      (STALL),
    .BRANCH     (BRANCH),
    .bOFFSET    (bOFFSET),
    .bSIGN      (bSIGN),
    .SOFT_RST   (SOFT_RST),
    .HALT_REQ   (HALT_REQ),
    .PC         (PC),
    .FETCH_EN   (FETCH_EN),
    .DONE       (DONE),
    .CYCLE_CNT  (CYCLE_CNT)
  );

  always #5 CLK = ~CLK;

  function automatic void chk(string nm, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", nm, got, want, $time);
    end
  endfunction

  function automatic int exp_cnt();
`ifdef SEQ_CYCLE_COUNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_pc = 0; m_base = 0; m_cnt = 0;
  endfunction

  function automatic void model_step(bit st, int sa, bit stl, bit br, int off, bit sg, bit sr, bit hl);
    if (m_mode != 1) begin
      if (st) begin
        m_mode = 1; m_pc = sa; m_base = sa; m_cnt = 0;
      end
    end else if (!stl) begin
      if (m_cnt < 65535) m_cnt++;
      if (hl) begin
        m_mode = 2;
        if (sr) m_pc = m_base;
      end else if (sr) m_pc = m_base;
      else if (br) m_pc = sg ? (m_pc - off + PC_MOD) % PC_MOD : (m_pc + off) % PC_MOD;
      else m_pc = (m_pc + 1) % PC_MOD;
    end
  endfunction

  task automatic cyc(bit st, int sa, bit stl, bit br, int off, bit sg, bit sr, bit hl);
    exp_t e;
    @(negedge CLK);
    START = st; START_ADDR = PC_W'(sa); STALL = stl; BRANCH = br;
    bOFFSET = 8'(off); bSIGN = sg; SOFT_RST = sr; HALT_REQ = hl;
    model_step(st, sa, stl, br, off, sg, sr, hl);
    e.pc = PC_W'(m_pc); e.fe = (m_mode == 1); e.done = (m_mode == 2); e.cnt = 16'(exp_cnt());
    exp_q.push_back(e);
  endtask

  task automatic drain();
    @(posedge CLK); #2;
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_idle_reset(string nm);
    chk({nm, "_pc"}, int'(PC), 0);
    chk({nm, "_fe"}, int'(FETCH_EN), 0);
    chk({nm, "_done"}, int'(DONE), 0);
    chk({nm, "_cnt"}, int'(CYCLE_CNT), 0);
  endtask

  // Monitor: one line per popped transaction.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc", int'(PC), int'(e.pc));
        chk("fetch_en", int'(FETCH_EN), int'(e.fe));
        chk("done", int'(DONE), int'(e.done));
        chk("cycle_cnt", int'(CYCLE_CNT), int'(e.cnt));
        $display("txn t=%0t pc=%03h fe=%0b done=%0b cnt=%0d", $time, PC, FETCH_EN, DONE, CYCLE_CNT);
      end
    end
  end

  initial begin
    RESET_N = 1'b0; START = 0; START_ADDR = '0; STALL = 0; BRANCH = 0;
    bOFFSET = '0; bSIGN = 0; SOFT_RST = 0; HALT_REQ = 0;
    model_reset();
    #12;
    check_idle_reset("reset");
    @(negedge CLK); RESET_N = 1'b1;

    // Directed sequence following the intended usage.
    cyc(0, 'h3FF, 0, 1, 7, 0, 1, 1);      // inputs ignored in IDLE
    cyc(1, 'h020, 0, 0, 0, 0, 0, 0);      // start
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 'h300, 0, 0, 0, 0, 0, 0);      // START in RUN ignored
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 'h0D, 0, 0, 0);       // to 0x030
    cyc(0, 0, 0, 1, 5, 1, 0, 0);          // 0x02B
    cyc(0, 0, 0, 1, 5, 0, 0, 0);          // 0x030
    cyc(0, 0, 0, 1, 5, 0, 0, 0);          // 0x035
    cyc(0, 0, 0, 1, 'h37, 1, 0, 0);       // 0x3FE
    cyc(0, 0, 0, 1, 4, 0, 0, 0);          // wrap to 0x002
    cyc(0, 0, 0, 1, 1, 1, 0, 0);          // 0x001
    cyc(0, 0, 0, 1, 3, 1, 0, 0);          // wrap to 0x3FE
    cyc(0, 0, 0, 1, 'h42, 0, 0, 0);       // 0x040
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 9, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);          // 0x041
    cyc(0, 0, 0, 1, 0, 0, 0, 0);          // spin, still retires
    cyc(0, 0, 0, 1, 'h14, 0, 0, 0);       // 0x055
    cyc(0, 0, 0, 0, 0, 0, 1, 1);          // halt + soft reset -> base
    cyc(0, 0, 0, 1, 3, 0, 0, 0);          // halted holds
    cyc(1, 'h100, 0, 0, 0, 0, 0, 0);      // restart
    for (int i = 0; i < 7; i++) cyc(0, 0, (i == 1 || i == 3), 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);          // halt without soft reset
    cyc(1, 'h3FD, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0);
    drain();

    // Asynchronous reset mid-RUN, sampled away from any edge.
    @(negedge CLK); #2; RESET_N = 1'b0; #1;
    model_reset();
    check_idle_reset("async_reset");
    @(negedge CLK); RESET_N = 1'b1;

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      bit st, stl, br, sg, sr, hl;
      int sa, off;
      st  = ($urandom_range(0, 9) == 0);
      sa  = $urandom_range(0, PC_MOD - 1);
      stl = ($urandom_range(0, 4) == 0);
      br  = ($urandom_range(0, 2) == 0);
      off = $urandom_range(0, 255);
      sg  = $urandom_range(0, 1);
      sr  = ($urandom_range(0, 19) == 0);
      hl  = ($urandom_range(0, 24) == 0);
      cyc(st, sa, stl, br, off, sg, sr, hl);
      if (n % 500 == 499) begin
        drain();
        @(negedge CLK); #3; RESET_N = 1'b0; #1;
        model_reset();
        check_idle_reset("rand_reset");
        @(negedge CLK); RESET_N = 1'b1;
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
